// File: rtl/freq_gen.sv
// freq_gen: programmable 50%-duty square-wave generator.
// A requested frequency in Hz is converted to a period in clkin cycles by a
// restoring sequential divider (one quotient bit per cycle). New settings and
// stop requests take effect only at period boundaries, so a downstream meter
// always sees whole periods.
// Build option: define FREQ_GEN_QUAD_EN to generate the quadrature output
// pulse_b (lag/lead of P>>2 selected by dir); otherwise pulse_b is tied low.
module freq_gen #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned FX_W   = 15,
    parameter int unsigned FX_MIN = 1000,
    parameter int unsigned FX_MAX = 20000,
    parameter int unsigned PER_W  = 27
) (
    input  logic            clkin,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [FX_W-1:0] fx_set,
    input  logic            fx_valid,
    output logic            fx_ready,
    output logic [FX_W-1:0] fx_act,
    output logic            busy,
    output logic            pulse_out,
    output logic            pulse_b,
    input  logic            dir
);

    localparam int unsigned        DCNT_W      = $clog2(PER_W);
    localparam logic [PER_W-1:0]   LP_DIVIDEND = PER_W'(CLK_HZ);
    localparam logic [FX_W-1:0]    LP_FX_MIN   = FX_W'(FX_MIN);
    localparam logic [FX_W-1:0]    LP_FX_MAX   = FX_W'(FX_MAX);
    localparam logic [DCNT_W-1:0]  LP_DLAST    = DCNT_W'(PER_W - 1);

    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;
    typedef enum logic       {IDLE, RUN}                    gen_state_t;

    // Divider and pending-slot registers
    div_state_t         r_dstate;
    logic [PER_W-1:0]   r_dq;
    logic [FX_W-1:0]    r_rem;
    logic [FX_W-1:0]    r_dvs;
    logic [DCNT_W-1:0]  r_dcnt;
    logic               r_pend_valid;
    logic               r_pend_stop;
    logic [PER_W-1:0]   r_pend_per;
    logic [FX_W-1:0]    r_pend_fx;

    // Generator registers
    gen_state_t         r_state;
    logic [PER_W-1:0]   r_cnt;
    logic [PER_W-1:0]   r_per;
    logic [FX_W-1:0]    r_fx_act;
    logic               r_pulse;

    // Divider datapath and generator next-state wires
    logic               w_accept;
    logic               w_in_range;
    logic [FX_W:0]      w_rem_sh;
    logic               w_ge;
    logic [FX_W-1:0]    w_rem_nxt;
    logic [PER_W-1:0]   w_dq_nxt;
    logic               w_last;
    logic               w_cont;
    logic               w_consume;
    gen_state_t         w_state_nxt;
    logic [PER_W-1:0]   w_cnt_nxt;
    logic [PER_W-1:0]   w_per_nxt;
    logic [PER_W-1:0]   w_hi_nxt;
    logic [FX_W-1:0]    w_fx_nxt;
    logic               w_pulse_nxt;

    assign fx_ready  = (r_dstate == DIV_IDLE) && !r_pend_valid;
    assign busy      = !fx_ready;
    assign fx_act    = r_fx_act;
    assign pulse_out = r_pulse;

    assign w_accept   = fx_valid && fx_ready;
    assign w_in_range = (fx_set >= LP_FX_MIN) && (fx_set <= LP_FX_MAX);

    // One restoring-division step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        w_rem_sh  = {r_rem, r_dq[PER_W-1]};
        w_ge      = (w_rem_sh >= {1'b0, r_dvs});
        w_rem_nxt = w_ge ? FX_W'(w_rem_sh - {1'b0, r_dvs}) : w_rem_sh[FX_W-1:0];
        w_dq_nxt  = {r_dq[PER_W-2:0], w_ge};
    end

    // Divider FSM and pending slot: filled by a finished divide or an out-of-range STOP
    // The quotient is written into the pending slot on the same edge that enters
    // DIV_DONE, so the result is pending PER_W+1 cycles after acceptance.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_dstate     <= DIV_IDLE;
            r_dq         <= '0;
            r_rem        <= '0;
            r_dvs        <= '0;
            r_dcnt       <= '0;
            r_pend_valid <= 1'b0;
            r_pend_stop  <= 1'b0;
            r_pend_per   <= '0;
            r_pend_fx    <= '0;
        end else begin
            case (r_dstate)
                DIV_IDLE: begin
                    if (w_accept) begin
                        r_pend_fx <= fx_set;
                        if (w_in_range) begin
                            r_dstate <= DIV_RUN;
                            r_dq     <= LP_DIVIDEND;
                            r_rem    <= '0;
                            r_dvs    <= fx_set;
                            r_dcnt   <= '0;
                        end else begin
                            r_pend_valid <= 1'b1;
                            r_pend_stop  <= 1'b1;
                        end
                    end
                end
                DIV_RUN: begin
                    r_dq   <= w_dq_nxt;
                    r_rem  <= w_rem_nxt;
                    r_dcnt <= r_dcnt + 1'b1;
                    if (r_dcnt == LP_DLAST) begin
                        r_dstate     <= DIV_DONE;
                        r_pend_valid <= 1'b1;
                        r_pend_stop  <= 1'b0;
                        r_pend_per   <= w_dq_nxt;
                    end
                end
                DIV_DONE: r_dstate <= DIV_IDLE;
                default:  r_dstate <= DIV_IDLE;
            endcase
            if (w_consume) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // Generator next state: decisions are taken only in IDLE or at the last cycle of a period
    always_comb begin
        w_last      = (r_state == RUN) && (r_cnt == r_per - 1'b1);
        w_cont      = enable && !(r_pend_valid && r_pend_stop);
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_per_nxt   = r_per;
        w_fx_nxt    = r_fx_act;
        w_consume   = 1'b0;
        if (r_state == IDLE) begin
            w_cnt_nxt = '0;
            if (r_pend_valid && r_pend_stop) begin
                w_consume = 1'b1;
            end else if (r_pend_valid && enable) begin
                w_state_nxt = RUN;
                w_per_nxt   = r_pend_per;
                w_fx_nxt    = r_pend_fx;
                w_consume   = 1'b1;
            end
        end else if (w_last) begin
            w_cnt_nxt = '0;
            if (!w_cont) begin
                w_state_nxt = IDLE;
                w_fx_nxt    = '0;
                w_consume   = r_pend_valid && r_pend_stop;
            end else if (r_pend_valid) begin
                w_per_nxt = r_pend_per;
                w_fx_nxt  = r_pend_fx;
                w_consume = 1'b1;
            end
        end
        w_hi_nxt    = w_per_nxt - (w_per_nxt >> 1);
        w_pulse_nxt = (w_state_nxt == RUN) && (w_cnt_nxt < w_hi_nxt);
    end

    // Generator state, period counter and registered pulse output
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_per    <= '0;
            r_fx_act <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_per    <= w_per_nxt;
            r_fx_act <= w_fx_nxt;
            r_pulse  <= w_pulse_nxt;
        end
    end

`ifdef FREQ_GEN_QUAD_EN
    logic [PER_W-1:0] w_q;
    logic [PER_W:0]   w_ph;
    logic             w_b_nxt;
    logic             r_pulse_b;

    assign pulse_b = r_pulse_b;

    // Quadrature phase from the shared counter: lag by P>>2 (dir=0) or lead by P>>2 (dir=1)
    // The leading copy can only rise into a period that will actually start,
    // so its final high segment is gated by the same continue condition.
    always_comb begin
        w_q     = w_per_nxt >> 2;
        w_ph    = '0;
        w_b_nxt = 1'b0;
        if (w_state_nxt == RUN) begin
            if (!dir) begin
                if (w_cnt_nxt >= w_q) begin
                    w_ph = {1'b0, w_cnt_nxt - w_q};
                end else begin
                    w_ph = {1'b0, w_cnt_nxt} + {1'b0, w_per_nxt} - {1'b0, w_q};
                end
                w_b_nxt = (w_ph < {1'b0, w_hi_nxt});
            end else begin
                w_ph = {1'b0, w_cnt_nxt} + {1'b0, w_q};
                if (w_ph >= {1'b0, w_per_nxt}) begin
                    w_b_nxt = w_cont;
                end else begin
                    w_b_nxt = (w_ph < {1'b0, w_hi_nxt});
                end
            end
        end
    end

    // Registered quadrature output
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse_b <= 1'b0;
        end else begin
            r_pulse_b <= w_b_nxt;
        end
    end
`else
    logic w_unused_dir;

    assign w_unused_dir = dir;
    assign pulse_b      = 1'b0;
`endif

endmodule

// File: tb/tb_freq_gen.sv
// tb_freq_gen: directed bench for freq_gen with a scaled-down clock
// (CLK_HZ = 1 MHz) so periods are P = 1e6 / fx cycles.
`timescale 1ns/1ps
module tb_freq_gen;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned FX_W   = 15;
    localparam int unsigned PER_W  = 27;

    logic            clkin    = 1'b0;
    logic            rst_n    = 1'b0;
    logic            enable   = 1'b0;
    logic [FX_W-1:0] fx_set   = '0;
    logic            fx_valid = 1'b0;
    logic            dir      = 1'b0;
    logic            fx_ready;
    logic [FX_W-1:0] fx_act;
    logic            busy;
    logic            pulse_out;
    logic            pulse_b;

    int n_checks = 0;
    int n_errors = 0;

    freq_gen #(
        .CLK_HZ (CLK_HZ),
        .FX_W   (FX_W),
        .FX_MIN (1000),
        .FX_MAX (20000),
        .PER_W  (PER_W)
    ) dut (
        .clkin     (clkin),
        .rst_n     (rst_n),
        .enable    (enable),
        .fx_set    (fx_set),
        .fx_valid  (fx_valid),
        .fx_ready  (fx_ready),
        .fx_act    (fx_act),
        .busy      (busy),
        .pulse_out (pulse_out),
        .pulse_b   (pulse_b),
        .dir       (dir)
    );

    always #5 clkin = ~clkin;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic strobe(input int unsigned fx);
        fx_set   = FX_W'(fx);
        fx_valid = 1'b1;
        tick();
        fx_valid = 1'b0;
    endtask

    task automatic run_while(input logic val, input int limit, output int n);
        n = 0;
        while (pulse_out === val && n < limit) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_ready(input int limit, output int n);
        n = 0;
        while (fx_ready !== 1'b1 && n < limit) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (pulse_out !== 1'b0) begin n_errors++; $display("FAIL reset_pulse: got %b expected 0", pulse_out); end
        n_checks++; if (pulse_b !== 1'b0) begin n_errors++; $display("FAIL reset_pulse_b: got %b expected 0", pulse_b); end
        n_checks++; if (fx_act !== '0) begin n_errors++; $display("FAIL reset_fx_act: got %0d expected 0", fx_act); end
        n_checks++; if (fx_ready !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL reset_ready_busy: got %b%b expected 10", fx_ready, busy); end
        tick();
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();
    endtask

    task automatic test_start_1000();
        int n;
        strobe(1000);
        wait_ready(100, n);
        n_checks++; if (n !== 28) begin n_errors++; $display("FAIL start_ready_low: got %0d expected 28", n); end
        n_checks++; if (pulse_out !== 1'b1) begin n_errors++; $display("FAIL start_rise: got %b expected 1", pulse_out); end
        n_checks++; if (fx_act !== 15'd1000) begin n_errors++; $display("FAIL start_fx_act: got %0d expected 1000", fx_act); end
        run_while(1'b1, 2000, n);
        n_checks++; if (n !== 500) begin n_errors++; $display("FAIL start_high: got %0d expected 500", n); end
        run_while(1'b0, 2000, n);
        n_checks++; if (n !== 500) begin n_errors++; $display("FAIL start_low: got %0d expected 500", n); end
    endtask

    task automatic test_change_2000();
        int n;
        int m;
        strobe(2000);
        strobe(5000);
        run_while(1'b1, 2000, m);
        n = m + 2;
        n_checks++; if (n !== 500) begin n_errors++; $display("FAIL change_old_high: got %0d expected 500", n); end
        run_while(1'b0, 2000, n);
        n_checks++; if (n !== 500) begin n_errors++; $display("FAIL change_old_low: got %0d expected 500", n); end
        n_checks++; if (fx_act !== 15'd2000 || fx_ready !== 1'b1) begin n_errors++; $display("FAIL change_fx_act: got %0d ready %b expected 2000 ready 1", fx_act, fx_ready); end
        run_while(1'b1, 2000, n);
        n_checks++; if (n !== 250) begin n_errors++; $display("FAIL change_new_high: got %0d expected 250", n); end
        run_while(1'b0, 2000, n);
        n_checks++; if (n !== 250) begin n_errors++; $display("FAIL change_new_low: got %0d expected 250", n); end
    endtask

    task automatic test_stop_out_of_range();
        int n;
        int m;
        strobe(25000);
        run_while(1'b1, 2000, m);
        n = m + 1;
        n_checks++; if (n !== 250) begin n_errors++; $display("FAIL stop_last_high: got %0d expected 250", n); end
        run_while(1'b0, 600, n);
        n_checks++; if (n !== 600) begin n_errors++; $display("FAIL stop_stays_low: got %0d expected 600", n); end
        n_checks++; if (fx_act !== '0 || fx_ready !== 1'b1) begin n_errors++; $display("FAIL stop_idle: got fx_act %0d ready %b expected 0 ready 1", fx_act, fx_ready); end
        strobe(500);
        n_checks++; if (fx_ready !== 1'b0) begin n_errors++; $display("FAIL stop_low_pending: got %b expected 0", fx_ready); end
        tick();
        n_checks++; if (fx_ready !== 1'b1 || pulse_out !== 1'b0) begin n_errors++; $display("FAIL stop_low_consumed: got ready %b pulse %b expected 1 0", fx_ready, pulse_out); end
    endtask

    task automatic test_freq_3000();
        int n;
        int h;
        int l;
        strobe(3000);
        wait_ready(100, n);
        n_checks++; if (n !== 28 || pulse_out !== 1'b1) begin n_errors++; $display("FAIL f3000_start: got %0d pulse %b expected 28 pulse 1", n, pulse_out); end
        run_while(1'b1, 1000, h);
        run_while(1'b0, 1000, l);
        n_checks++; if (h !== 167 || l !== 166) begin n_errors++; $display("FAIL f3000_phases: got %0d/%0d expected 167/166", h, l); end
        run_while(1'b1, 1000, h);
        run_while(1'b0, 1000, l);
        n_checks++; if (h + l !== 333) begin n_errors++; $display("FAIL f3000_period: got %0d expected 333", h + l); end
    endtask

    task automatic test_enable();
        int n;
        int m;
        enable = 1'b0;
        repeat (10) tick();
        enable = 1'b1;
        run_while(1'b1, 1000, m);
        n = m + 10;
        n_checks++; if (n !== 167) begin n_errors++; $display("FAIL en_glitch_high: got %0d expected 167", n); end
        run_while(1'b0, 1000, n);
        n_checks++; if (n !== 166 || fx_act !== 15'd3000) begin n_errors++; $display("FAIL en_glitch_low: got %0d fx %0d expected 166 fx 3000", n, fx_act); end
        enable = 1'b0;
        run_while(1'b1, 1000, n);
        run_while(1'b0, 400, n);
        n_checks++; if (n !== 400 || fx_act !== '0) begin n_errors++; $display("FAIL en_off_stop: got %0d fx %0d expected 400 fx 0", n, fx_act); end
        strobe(20000);
        repeat (40) tick();
        n_checks++; if (pulse_out !== 1'b0 || fx_ready !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL en_pending_held: got pulse %b ready %b busy %b expected 0 0 1", pulse_out, fx_ready, busy); end
        enable = 1'b1;
        tick();
        n_checks++; if (pulse_out !== 1'b1 || fx_act !== 15'd20000) begin n_errors++; $display("FAIL en_restart: got pulse %b fx %0d expected 1 fx 20000", pulse_out, fx_act); end
        run_while(1'b1, 100, n);
        n_checks++; if (n !== 25) begin n_errors++; $display("FAIL max_high: got %0d expected 25", n); end
        run_while(1'b0, 100, n);
        n_checks++; if (n !== 25) begin n_errors++; $display("FAIL max_low: got %0d expected 25", n); end
    endtask

    task automatic test_reject_edges();
        int n;
        int m;
        strobe(20001);
        run_while(1'b1, 100, m);
        n = m + 1;
        n_checks++; if (n !== 25) begin n_errors++; $display("FAIL rej_hi_last: got %0d expected 25", n); end
        run_while(1'b0, 100, n);
        n_checks++; if (n !== 100 || fx_act !== '0) begin n_errors++; $display("FAIL rej_hi_stop: got %0d fx %0d expected 100 fx 0", n, fx_act); end
        strobe(999);
        repeat (40) tick();
        n_checks++; if (pulse_out !== 1'b0 || fx_ready !== 1'b1) begin n_errors++; $display("FAIL rej_lo: got pulse %b ready %b expected 0 1", pulse_out, fx_ready); end
    endtask

    task automatic test_loopback_1500();
        int n;
        int h;
        int l;
        strobe(1500);
        wait_ready(100, n);
        n_checks++; if (fx_act !== 15'd1500) begin n_errors++; $display("FAIL loop_fx_act: got %0d expected 1500", fx_act); end
        run_while(1'b1, 1000, h);
        run_while(1'b0, 1000, l);
        n_checks++; if (h + l !== 666) begin n_errors++; $display("FAIL loop_period: got %0d expected 666", h + l); end
`ifdef FREQ_GEN_QUAD_EN
        n = 0;
        while (pulse_b !== 1'b1 && n < 1000) begin n++; tick(); end
        n_checks++; if (n !== 166) begin n_errors++; $display("FAIL quad_lag: got %0d expected 166", n); end
        dir = 1'b1;
        n = 0;
        while (pulse_b === 1'b1 && n < 1000) begin n++; tick(); end
        n = 0;
        while (pulse_b !== 1'b1 && n < 1000) begin n++; tick(); end
        n = 0;
        while (pulse_out !== 1'b1 && n < 1000) begin n++; tick(); end
        n_checks++; if (n !== 166) begin n_errors++; $display("FAIL quad_lead: got %0d expected 166", n); end
`else
        n = 0;
        for (int i = 0; i < 700; i++) begin
            dir = i[3];
            if (pulse_b !== 1'b0) n++;
            tick();
        end
        n_checks++; if (n !== 0) begin n_errors++; $display("FAIL quad_off: got %0d high samples expected 0", n); end
`endif
    endtask

    task automatic test_async_reset();
        int n;
        run_while(1'b1, 1000, n);
        run_while(1'b0, 1000, n);
        repeat (5) tick();
        n_checks++; if (pulse_out !== 1'b1) begin n_errors++; $display("FAIL ares_pre_high: got %b expected 1", pulse_out); end
        rst_n = 1'b0;
        #2;
        n_checks++; if (pulse_out !== 1'b0 || fx_ready !== 1'b1 || fx_act !== '0) begin n_errors++; $display("FAIL ares_now: got pulse %b ready %b fx %0d expected 0 1 0", pulse_out, fx_ready, fx_act); end
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (pulse_out !== 1'b0) n++;
        end
        n_checks++; if (n !== 0 || fx_act !== '0) begin n_errors++; $display("FAIL ares_quiet: got %0d high, fx %0d expected 0 0", n, fx_act); end
    endtask

    initial begin
        test_reset();
        test_start_1000();
        test_change_2000();
        test_stop_out_of_range();
        test_freq_3000();
        test_enable();
        test_reject_edges();
        test_loopback_1500();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/freq_gen.md
Name: freq_gen

Overview:
Programmable square-wave generator, the transmit-side counterpart of the chassis frequency meter. It converts a requested frequency in Hz into a period in clkin cycles using an on-block sequential divider. It drives a 50%-duty pulse train, used to emulate encoder/Hall feedback for bench and closed-loop tests. New settings are applied glitch-free at period boundaries, so a downstream meter always sees whole periods.

Parameters:
CLK_HZ, 100_000_000, clkin frequency; dividend for period computation
FX_W, 15, width of frequency request in Hz
FX_MIN, 1000, lowest accepted frequency (matches meter window, period <= 100000)
FX_MAX, 20000, highest accepted frequency (period >= 5000)
PER_W, 27, period counter / divider width; must hold CLK_HZ

Ports:
clkin  in  1  base clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  run request; low stops output at next period boundary
fx_set  in  FX_W  requested frequency, Hz
fx_valid  in  1  request strobe; accepted when fx_valid & fx_ready
fx_ready  out  1  high when divider idle and no result pending
fx_act  out  FX_W  frequency currently being generated; 0 when stopped
busy  out  1  divider running or result pending
pulse_out  out  1  generated square wave
pulse_b  out  1  quadrature phase (see Optional Feature)
dir  in  1  quadrature direction select (see Optional Feature)

Behaviour:
- Reset (async): pulse_out=0, pulse_b=0, fx_act=0, busy=0, fx_ready=1, state IDLE, period regs=0, pending flag=0. Reset mid-period forces pulse_out low immediately.
- States: IDLE (output low), RUN (toggling). Divider FSM runs independently: DIV_IDLE -> DIV_RUN (PER_W cycles, restoring, 1 bit/cycle) -> DIV_DONE (1 cycle, writes pending).
- Accept: fx_set range check on the acceptance cycle. If FX_MIN <= fx_set <= FX_MAX, start the divider with period = floor(CLK_HZ / fx_set). Otherwise no divide: pending = STOP, latched next cycle.
- Divider latency: result pending exactly PER_W+1 cycles after acceptance. fx_ready=0 from acceptance until pending is consumed.
- Waveform per period P: high for P - (P>>1) cycles, then low for P>>1 cycles; total exactly P. The period boundary is the cycle pulse_out rises.
- IDLE with valid pending and enable=1: pulse_out rises on the next cycle; state RUN; fx_act=pending fx.
- RUN: at each boundary, if pending is valid, load the new P and fx_act, and clear pending. If pending is STOP or enable=0, pulse_out stays low, fx_act=0, and state returns to IDLE. The current period is never truncated.
- fx_valid while fx_ready=0 is ignored (no queue).
- enable deasserted then reasserted before a boundary: no effect on output.
- Pending survives enable=0; output restarts from IDLE when enable returns.
- All counters compare against the latched P only; fx_set may change freely after acceptance.

Optional Feature:
- Macro FREQ_GEN_QUAD_EN.
- Defined: pulse_b is a copy of pulse_out delayed by P>>2 cycles when dir=0. When dir=1, pulse_b leads pulse_out by P>>2 cycles (generated from the same counter, phase offset P - (P>>2)). pulse_b follows period and stop transitions aligned with its own phase. Reset: pulse_b=0.
- Not defined: pulse_b tied 0, dir ignored, no quadrature logic synthesized.

Test Plan:
- Reset release, enable=1, fx_set=1000 strobed: fx_ready low 28 cycles. pulse_out rises next cycle, then high 50000 / low 50000 repeating; fx_act=1000.
- fx_set=3000: P=33333, high 16667, low 16666 cycles; measured period exactly 33333.
- Running at 1000, request 2000 during the high phase: current 100000-cycle period completes, next period 50000, no runt pulse.
- fx_set=500 or 25000 while running: the period in progress completes, then pulse_out stays 0, fx_act=0, state IDLE.
- rst_n pulsed low mid-high-phase: pulse_out=0 asynchronously, fx_ready=1, no output until a new request.
- Loopback into the meter, fx_set=1500 (P=66666): meter reports 1500. With FREQ_GEN_QUAD_EN, dir=0: pulse_b rise lags pulse_out rise by 16666 cycles; dir=1: pulse_b leads by 16666 cycles.
